// File: rtl/seq_det_pkg.sv
// Shared constants and sizing helper for the programmable serial-pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  // Width needed to hold a length of 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register, fill counter and length-masked pattern compare.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_width(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic               restart,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] window;
  logic [LEN_W:0]     fill_plus;
  logic               enough;
  logic               same;

  assign window    = {hist, din};
  assign fill_plus = {1'b0, fill} + 1'b1;
  assign enough    = (fill_plus >= {1'b0, len});

  // Only the low len bits of the window take part in the compare.
  always_comb begin
    same = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len) && (window[i] != pattern[i])) same = 1'b0;
    end
  end

  assign hit = enough & same;

  // A non-overlapping hit restarts the fill so the next match needs a full fresh pattern.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= window[MAX_LEN-2:0];
      if (restart)
        fill <= '0;
      else if (fill != LEN_W'(MAX_LEN - 1))
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable Mealy serial-pattern detector with overlap mode and saturating match counter.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_width(DEF_MAX_LEN),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               accept;
  logic               hit;

  // Configuration is only sampled on cfg_load; reset leaves a 1-bit all-zero pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= '0;
      len     <= LEN_W'(1);
      overlap <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= cfg_len;
      overlap <= cfg_overlap;
      cfg_err <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
    end
  end

  assign accept = din_valid & ~cfg_load;
  assign match  = accept & ~cfg_err & hit;

  seq_det_window #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .clear  (cfg_load),
    .accept (accept),
    .restart(match & ~overlap),
    .din    (din),
    .pattern(pattern),
    .len    (len),
    .hit    (hit)
  );

  // A clear in the same cycle as a match wins, so that match is not counted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      match_cnt <= '0;
    else if (match && (match_cnt != '1))
      match_cnt <= match_cnt + 1'b1;
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (counter narrowed to 2 bits).
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  int vectors = 0;
  int miscompares = 0;

  seq_detect_prog #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .din_valid  (din_valid),
    .din        (din),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Drive one stream bit for a cycle; return match sampled mid-cycle.
  task automatic send_bit(input logic b, output logic m);
    din_valid = 1'b1;
    din       = b;
    @(negedge clk);
    m = match;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  // Send n bits (first bit = bits[n-1]) and compare match per bit against exp[n-1..0].
  task automatic run_stream(input string name, input logic [15:0] bits, input logic [15:0] exp,
                            input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], m);
      vectors++;
      if (m !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL %s bit%0d: match=%b expected %b", name, n - i, m, exp[i]);
      end
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp);
    @(negedge clk);
    vectors++;
    if (match_cnt !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: match_cnt=%0d expected %0d", name, match_cnt, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic m;
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    vectors++;
    if (match_cnt !== 2'd0 || cfg_err !== 1'b0 || match !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset: cnt=%0d err=%b match=%b expected 0 0 0", match_cnt, cfg_err, match);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Default config is a single 0 bit.
    send_bit(1'b0, m);
    vectors++;
    if (m !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_default_zero: match=%b expected 1", m);
    end
    send_bit(1'b1, m);
    vectors++;
    if (m !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_default_one: match=%b expected 0", m);
    end
    check_cnt("reset_cnt", 2'd1);
  endtask

  task automatic test_nonoverlap();
    load_cfg(8'b101, 4'd3, 1'b0);
    clear_cnt();
    run_stream("nonovl_101", 16'b10101, 16'b00100, 5);
    check_cnt("nonovl_cnt", 2'd1);
  endtask

  task automatic test_overlap();
    load_cfg(8'b101, 4'd3, 1'b1);
    clear_cnt();
    run_stream("ovl_101", 16'b10101, 16'b00101, 5);
    check_cnt("ovl_cnt", 2'd2);
  endtask

  task automatic test_len4();
    load_cfg(8'b1101, 4'd4, 1'b1);
    clear_cnt();
    run_stream("len4_ovl", 16'b1101101, 16'b0001001, 7);
    check_cnt("len4_ovl_cnt", 2'd2);
    load_cfg(8'b1101, 4'd4, 1'b0);
    clear_cnt();
    run_stream("len4_nonovl", 16'b1101101, 16'b0001000, 7);
    check_cnt("len4_nonovl_cnt", 2'd1);
  endtask

  task automatic test_gaps();
    logic m;
    logic [2:0] bits = 3'b101;
    logic [2:0] exp  = 3'b001;
    load_cfg(8'b101, 4'd3, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i], m);
      vectors++;
      if (m !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL gaps bit%0d: match=%b expected %b", 3 - i, m, exp[i]);
      end
      for (int g = 0; g < 3; g++) begin
        din = 1'b1;
        @(negedge clk);
        vectors++;
        if (match !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL gaps_idle: match=%b expected 0", match);
        end
        @(posedge clk); #1;
        din = 1'b0;
      end
    end
  endtask

  task automatic test_cfg_err();
    clear_cnt();
    load_cfg(8'b0, 4'd0, 1'b1);
    @(negedge clk);
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cfg_err_len0: cfg_err=%b expected 1", cfg_err);
    end
    @(posedge clk); #1;
    run_stream("cfg_err_len0_stream", 16'b01001100, 16'b0, 8);
    load_cfg(8'hFF, 4'd9, 1'b1);
    @(negedge clk);
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cfg_err_len9: cfg_err=%b expected 1", cfg_err);
    end
    @(posedge clk); #1;
    run_stream("cfg_err_len9_stream", 16'hFFFF, 16'b0, 16);
    check_cnt("cfg_err_cnt_held", 2'd0);
    load_cfg(8'b101, 4'd3, 1'b0);
    @(negedge clk);
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cfg_err_len3: cfg_err=%b expected 0", cfg_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    logic m;
    logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load_cfg(8'b1, 4'd1, 1'b0);
    clear_cnt();
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, m);
      check_cnt("saturate", exp_cnt[i]);
    end
    // Clear coinciding with a match: the match is lost.
    cnt_clr = 1'b1;
    send_bit(1'b1, m);
    cnt_clr = 1'b0;
    vectors++;
    if (m !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_with_match_pulse: match=%b expected 1", m);
    end
    check_cnt("clr_with_match_cnt", 2'd0);
  endtask

  task automatic test_back_to_back();
    load_cfg(8'b10110011, 4'd8, 1'b0);
    clear_cnt();
    run_stream("len8_nonovl", 16'b1011001110110011, 16'b0000000100000001, 16);
    check_cnt("len8_nonovl_cnt", 2'd2);
    load_cfg(8'hFF, 4'd8, 1'b1);
    clear_cnt();
    run_stream("len8_ones_ovl", 16'b1111111111, 16'b0000000111, 10);
    check_cnt("len8_ones_cnt", 2'd3);
  endtask

  task automatic test_rst_mid();
    logic m;
    load_cfg(8'b101, 4'd3, 1'b1);
    send_bit(1'b1, m);
    send_bit(1'b0, m);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send_bit(1'b1, m);
    vectors++;
    if (m !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_prefix: match=%b expected 0", m);
    end
    send_bit(1'b0, m);
    vectors++;
    if (m !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_default_cfg: match=%b expected 1", m);
    end
  endtask

  task automatic test_load_with_valid();
    load_cfg(8'b101, 4'd3, 1'b1);
    run_stream("load_prefix", 16'b10, 16'b00, 2);
    // Reload while a completing bit is presented: load wins, bit is dropped.
    din_valid = 1'b1;
    din       = 1'b1;
    cfg_load  = 1'b1;
    @(negedge clk);
    vectors++;
    if (match !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_with_valid: match=%b expected 0", match);
    end
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    run_stream("load_after", 16'b0101, 16'b0001, 4);
  endtask

  initial begin
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    #1;
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_len4();
    test_gaps();
    test_cfg_err();
    test_saturate();
    test_back_to_back();
    test_rst_mid();
    test_load_with_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
